// File: rtl/exu_pkg.sv
// ----------------------------------------------------------------------------
// exu_pkg
// Shared types for the execute-stage arithmetic core (alu_bru_mul):
//   u32_t / u64_t  : datapath word types
//   alu_op_t       : 4-bit ALU operation code
//   bru_op_t       : 3-bit branch condition code
//   mul_state_t    : multiplier FSM state, exposed for debug
//   mul_product()  : full 64-bit product with signed/unsigned operand extension
// ----------------------------------------------------------------------------
package exu_pkg;

   typedef logic [31:0] u32_t;
   typedef logic [63:0] u64_t;

   typedef enum logic [3:0] {
      ALU_ADD   = 4'd0,
      ALU_SUB   = 4'd1,
      ALU_SLT   = 4'd2,
      ALU_SLTU  = 4'd3,
      ALU_AND   = 4'd4,
      ALU_OR    = 4'd5,
      ALU_XOR   = 4'd6,
      ALU_NOR   = 4'd7,
      ALU_SLL   = 4'd8,
      ALU_SRL   = 4'd9,
      ALU_SRA   = 4'd10,
      ALU_PASSB = 4'd11
   } alu_op_t;

   typedef enum logic [2:0] {
      BRU_NONE   = 3'd0,
      BRU_EQ     = 3'd1,
      BRU_NE     = 3'd2,
      BRU_LT     = 3'd3,
      BRU_GE     = 3'd4,
      BRU_LTU    = 3'd5,
      BRU_GEU    = 3'd6,
      BRU_ALWAYS = 3'd7
   } bru_op_t;

   typedef enum logic [1:0] {
      MUL_IDLE = 2'd0,
      MUL_CALC = 2'd1,
      MUL_DONE = 2'd2
   } mul_state_t;

   // Extending both operands to 64 bits and keeping the low 64 bits of the
   // product gives the exact result in both signed and unsigned modes.
   function automatic u64_t mul_product(input u32_t a, input u32_t b, input logic sgn);
      u64_t ea;
      u64_t eb;
      ea = sgn ? {{32{a[31]}}, a} : {32'b0, a};
      eb = sgn ? {{32{b[31]}}, b} : {32'b0, b};
      return ea * eb;
   endfunction

endpackage

// File: rtl/alu_bru_mul_if.sv
// ----------------------------------------------------------------------------
// alu_bru_mul_if
// Multiplier request/response bundle of the execute stage.
//   master (pipeline side): drives mul_en, mul_signed, mul_flush, mul_a, mul_b
//   slave  (multiplier)   : drives mul_out, mul_done, mul_state (debug)
//
// Handshake: the requester raises mul_en with operands and keeps it high until
// it sees mul_done. mul_done is a one-cycle pulse; mul_out is valid in that
// cycle and holds until the next completion. mul_flush aborts any request in
// flight, wins over mul_en and suppresses mul_done.
// ----------------------------------------------------------------------------
interface alu_bru_mul_if;
   import exu_pkg::*;

   logic       mul_en;
   logic       mul_signed;
   logic       mul_flush;
   u32_t       mul_a;
   u32_t       mul_b;
   u64_t       mul_out;
   logic       mul_done;
   mul_state_t mul_state;

   modport master (
      output mul_en, mul_signed, mul_flush, mul_a, mul_b,
      input  mul_out, mul_done, mul_state
   );

   modport slave (
      input  mul_en, mul_signed, mul_flush, mul_a, mul_b,
      output mul_out, mul_done, mul_state
   );
endinterface

// File: rtl/mul_unit.sv
// ----------------------------------------------------------------------------
// mul_unit
// 32x32->64 multiplier of the execute stage.
//   clk, rst_n : clock, synchronous active-low reset
//   mul        : alu_bru_mul_if.slave request/response bundle
//
// Build option EXU_MUL_PIPE_EN:
//   defined   : IDLE -> CALC -> DONE FSM, operands captured in IDLE, product
//               registered in CALC, mul_done pulses in DONE (en at N -> done
//               at N+2).
//   undefined : combinational multiplier, mul_done = mul_en & ~mul_flush,
//               no state; clk/rst_n have no effect.
// ----------------------------------------------------------------------------
module mul_unit
   import exu_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   alu_bru_mul_if.slave       mul
);

`ifdef EXU_MUL_PIPE_EN

   mul_state_t state_q;
   mul_state_t state_d;
   u32_t       a_q;
   u32_t       b_q;
   logic       sgn_q;
   u64_t       out_q;
   logic       capture;
   logic       load_out;
   logic       done_c;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= MUL_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sgn_q   <= 1'b0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         if (capture) begin
            a_q   <= mul.mul_a;
            b_q   <= mul.mul_b;
            sgn_q <= mul.mul_signed;
         end
         if (load_out) begin
            out_q <= mul_product(a_q, b_q, sgn_q);
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      capture  = 1'b0;
      load_out = 1'b0;
      done_c   = 1'b0;
      case (state_q)
         MUL_IDLE: begin
            if (mul.mul_en) begin
               capture = 1'b1;
               state_d = MUL_CALC;
            end
         end
         MUL_CALC: begin
            load_out = 1'b1;
            state_d  = MUL_DONE;
         end
         MUL_DONE: begin
            done_c  = 1'b1;
            state_d = MUL_IDLE;
         end
         default: state_d = MUL_IDLE;
      endcase
      // Flush overrides everything: no capture, no product update, no done.
      if (mul.mul_flush) begin
         state_d  = MUL_IDLE;
         capture  = 1'b0;
         load_out = 1'b0;
         done_c   = 1'b0;
      end
   end

   assign mul.mul_out   = out_q;
   assign mul.mul_done  = done_c;
   assign mul.mul_state = state_q;

`else

   logic unused_clk_rst;
   assign unused_clk_rst = clk ^ rst_n;

   assign mul.mul_out   = mul_product(mul.mul_a, mul.mul_b, mul.mul_signed);
   assign mul.mul_done  = mul.mul_en & ~mul.mul_flush;
   assign mul.mul_state = MUL_IDLE;

`endif

endmodule

// File: rtl/alu_bru_mul.sv
// ----------------------------------------------------------------------------
// alu_bru_mul
// Execute-stage arithmetic core: combinational 32-bit ALU, combinational
// branch comparator (BRU) and the mul_unit multiplier.
//   clk, rst_n           : clock, synchronous active-low reset
//   alu_op, alu_a, alu_b : ALU operation and operands -> alu_out
//   bru_op, bru_a, bru_b : branch condition and operands -> br_taken
//   mul                  : alu_bru_mul_if.slave multiplier bundle
// Build option EXU_MUL_PIPE_EN selects the multi-cycle multiplier (see
// mul_unit); undefined gives the single-cycle combinational multiplier.
// ----------------------------------------------------------------------------
module alu_bru_mul
   import exu_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  alu_op_t       alu_op,
   input  u32_t          alu_a,
   input  u32_t          alu_b,
   output u32_t          alu_out,
   input  bru_op_t       bru_op,
   input  u32_t          bru_a,
   input  u32_t          bru_b,
   output logic          br_taken,
   alu_bru_mul_if.slave  mul
);

   logic [4:0] shamt;
   assign shamt = alu_b[4:0];

   always_comb begin
      alu_out = '0;
      case (alu_op)
         ALU_ADD:   alu_out = alu_a + alu_b;
         ALU_SUB:   alu_out = alu_a - alu_b;
         ALU_SLT:   alu_out = {31'b0, $signed(alu_a) < $signed(alu_b)};
         ALU_SLTU:  alu_out = {31'b0, alu_a < alu_b};
         ALU_AND:   alu_out = alu_a & alu_b;
         ALU_OR:    alu_out = alu_a | alu_b;
         ALU_XOR:   alu_out = alu_a ^ alu_b;
         ALU_NOR:   alu_out = ~(alu_a | alu_b);
         ALU_SLL:   alu_out = alu_a << shamt;
         ALU_SRL:   alu_out = alu_a >> shamt;
         ALU_SRA:   alu_out = u32_t'($signed(alu_a) >>> shamt);
         ALU_PASSB: alu_out = alu_b;
         default:   alu_out = '0;
      endcase
   end

   always_comb begin
      br_taken = 1'b0;
      case (bru_op)
         BRU_NONE:   br_taken = 1'b0;
         BRU_EQ:     br_taken = (bru_a == bru_b);
         BRU_NE:     br_taken = (bru_a != bru_b);
         BRU_LT:     br_taken = ($signed(bru_a) <  $signed(bru_b));
         BRU_GE:     br_taken = ($signed(bru_a) >= $signed(bru_b));
         BRU_LTU:    br_taken = (bru_a <  bru_b);
         BRU_GEU:    br_taken = (bru_a >= bru_b);
         BRU_ALWAYS: br_taken = 1'b1;
         default:    br_taken = 1'b0;
      endcase
   end

   mul_unit u_mul (
      .clk   (clk),
      .rst_n (rst_n),
      .mul   (mul)
   );

endmodule

// File: tb/tb_alu_bru_mul.sv
// ----------------------------------------------------------------------------
// tb_alu_bru_mul
// Self-checking bench for alu_bru_mul: directed ALU/BRU vector tables,
// randomized ALU/BRU/multiply against a reference model, and hand-written
// multiplier sequences (timing, flush, reset) for the EXU_MUL_PIPE_EN build.
// ----------------------------------------------------------------------------
module tb_alu_bru_mul;
   import exu_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   alu_op_t alu_op;
   u32_t    alu_a, alu_b, alu_out;
   bru_op_t bru_op;
   u32_t    bru_a, bru_b;
   logic    br_taken;

   alu_bru_mul_if mif();

   alu_bru_mul dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .alu_op   (alu_op),
      .alu_a    (alu_a),
      .alu_b    (alu_b),
      .alu_out  (alu_out),
      .bru_op   (bru_op),
      .bru_a    (bru_a),
      .bru_b    (bru_b),
      .br_taken (br_taken),
      .mul      (mif)
   );

   // ---------------- scoreboard ----------------
   int pass_cnt  = 0;
   int total_cnt = 0;
   logic [63:0] exp_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
   endtask

   // ---------------- reference model ----------------
   function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      int          sa, sb;
      int unsigned s;
      sa = $signed(a);
      sb = $signed(b);
      s  = b % 32;
      case (op)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return (sa < sb) ? 32'd1 : 32'd0;
         4'd3:    return (a < b) ? 32'd1 : 32'd0;
         4'd4:    return a & b;
         4'd5:    return a | b;
         4'd6:    return a ^ b;
         4'd7:    return ~(a | b);
         4'd8:    return a << s;
         4'd9:    return a >> s;
         4'd10:   return sa >>> s;
         4'd11:   return b;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic bru_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      int sa, sb;
      sa = $signed(a);
      sb = $signed(b);
      case (op)
         3'd1:    return a == b;
         3'd2:    return a != b;
         3'd3:    return sa < sb;
         3'd4:    return sa >= sb;
         3'd5:    return a < b;
         3'd6:    return a >= b;
         3'd7:    return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [63:0] mul_model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
      longint          sp;
      longint unsigned up;
      if (sgn) begin
         sp = longint'($signed(a)) * longint'($signed(b));
         return sp;
      end
      up = longint'({32'b0, a}) * longint'({32'b0, b});
      return up;
   endfunction

   // ---------------- vector tables ----------------
   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } alu_vec_t;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic        exp;
   } bru_vec_t;

   alu_vec_t alu_tab[15];
   bru_vec_t bru_tab[9];

   // ---------------- driver tasks ----------------
   task automatic drive_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      alu_op = alu_op_t'(op);
      alu_a  = a;
      alu_b  = b;
      #1;
   endtask

   task automatic drive_bru(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      bru_op = bru_op_t'(op);
      bru_a  = a;
      bru_b  = b;
      #1;
   endtask

   task automatic set_mul(input logic en, input logic [31:0] a, input logic [31:0] b, input logic sgn);
      mif.mul_en     = en;
      mif.mul_a      = a;
      mif.mul_b      = b;
      mif.mul_signed = sgn;
   endtask

   // ---------------- test ----------------
   initial begin
      logic [31:0] ra, rb;
      logic        rs;
      logic [63:0] e;

      alu_tab[0]  = '{4'd1,  32'd5,        32'd7,        32'hFFFFFFFE};
      alu_tab[1]  = '{4'd2,  32'hFFFFFFFF, 32'd1,        32'd1};
      alu_tab[2]  = '{4'd3,  32'hFFFFFFFF, 32'd1,        32'd0};
      alu_tab[3]  = '{4'd10, 32'h80000000, 32'd4,        32'hF8000000};
      alu_tab[4]  = '{4'd8,  32'd3,        32'h21,       32'd6};
      alu_tab[5]  = '{4'd0,  32'hFFFFFFFF, 32'd1,        32'd0};
      alu_tab[6]  = '{4'd9,  32'h80000000, 32'd31,       32'd1};
      alu_tab[7]  = '{4'd4,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000};
      alu_tab[8]  = '{4'd5,  32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0};
      alu_tab[9]  = '{4'd6,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0};
      alu_tab[10] = '{4'd7,  32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F};
      alu_tab[11] = '{4'd11, 32'h11111111, 32'h12345000, 32'h12345000};
      alu_tab[12] = '{4'd12, 32'h11111111, 32'h22222222, 32'd0};
      alu_tab[13] = '{4'd15, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0};
      alu_tab[14] = '{4'd2,  32'd1,        32'hFFFFFFFF, 32'd0};

      bru_tab[0] = '{3'd3, 32'hFFFFFFFF, 32'd0,        1'b1};
      bru_tab[1] = '{3'd5, 32'hFFFFFFFF, 32'd0,        1'b0};
      bru_tab[2] = '{3'd6, 32'h12345678, 32'h12345678, 1'b1};
      bru_tab[3] = '{3'd0, 32'd5,        32'd5,        1'b0};
      bru_tab[4] = '{3'd7, 32'd1,        32'd2,        1'b1};
      bru_tab[5] = '{3'd1, 32'd5,        32'd5,        1'b1};
      bru_tab[6] = '{3'd2, 32'd5,        32'd5,        1'b0};
      bru_tab[7] = '{3'd4, 32'd0,        32'hFFFFFFFF, 1'b1};
      bru_tab[8] = '{3'd6, 32'd0,        32'hFFFFFFFF, 1'b0};

      rst_n = 1'b0;
      alu_op = ALU_ADD; alu_a = '0; alu_b = '0;
      bru_op = BRU_NONE; bru_a = '0; bru_b = '0;
      mif.mul_flush = 1'b0;
      set_mul(1'b0, 32'd0, 32'd0, 1'b0);
      repeat (2) @(negedge clk);

      check("reset_done",  {63'd0, mif.mul_done}, 64'd0);
      check("reset_out",   mif.mul_out, 64'd0);
      check("reset_state", 64'(mif.mul_state), 64'(MUL_IDLE));
      rst_n = 1'b1;
      @(negedge clk);

      // ALU / BRU directed tables
      foreach (alu_tab[i]) begin
         drive_alu(alu_tab[i].op, alu_tab[i].a, alu_tab[i].b);
         check($sformatf("alu_vec%0d", i), {32'd0, alu_out}, {32'd0, alu_tab[i].exp});
      end
      foreach (bru_tab[i]) begin
         drive_bru(bru_tab[i].op, bru_tab[i].a, bru_tab[i].b);
         check($sformatf("bru_vec%0d", i), {63'd0, br_taken}, {63'd0, bru_tab[i].exp});
      end

      // ALU / BRU randomized against the model
      for (int i = 0; i < 150; i++) begin
         ra = $urandom();
         rb = ($urandom_range(0, 3) == 0) ? ra : $urandom();
         drive_alu(4'($urandom_range(0, 15)), ra, rb);
         check("alu_rand", {32'd0, alu_out}, {32'd0, alu_model(alu_op, ra, rb)});
         drive_bru(3'($urandom_range(0, 7)), ra, rb);
         check("bru_rand", {63'd0, br_taken}, {63'd0, bru_model(bru_op, ra, rb)});
      end

`ifdef EXU_MUL_PIPE_EN
      // Unsigned max x max: done exactly at N+2 for a single cycle.
      @(negedge clk);
      set_mul(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
      @(negedge clk);
      check("t_calc_done", {63'd0, mif.mul_done}, 64'd0);
      set_mul(1'b1, 32'h0, 32'h0, 1'b1);  // operands change after capture
      @(negedge clk);
      check("t_done",     {63'd0, mif.mul_done}, 64'd1);
      check("t_out",      mif.mul_out, 64'hFFFFFFFE00000001);
      set_mul(1'b0, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      check("t_done_once", {63'd0, mif.mul_done}, 64'd0);
      check("t_out_hold",  mif.mul_out, 64'hFFFFFFFE00000001);

      // Signed -2 x 3, then the same operands unsigned.
      for (int s = 1; s >= 0; s--) begin
         set_mul(1'b1, 32'hFFFFFFFE, 32'd3, 1'(s));
         repeat (2) @(negedge clk);
         check("sgn_done", {63'd0, mif.mul_done}, 64'd1);
         check("sgn_out",  mif.mul_out, (s == 1) ? 64'hFFFFFFFFFFFFFFFA : 64'h00000002FFFFFFFA);
         set_mul(1'b0, 32'h0, 32'h0, 1'b0);
         @(negedge clk);
      end

      // Flush wins over en in IDLE.
      set_mul(1'b1, 32'd9, 32'd9, 1'b0);
      mif.mul_flush = 1'b1;
      @(negedge clk);
      check("flush_idle_state", 64'(mif.mul_state), 64'(MUL_IDLE));
      mif.mul_flush = 1'b0;
      set_mul(1'b0, 32'd0, 32'd0, 1'b0);
      @(negedge clk);

      // Flush in CALC: no done; a new request completes 2 cycles later.
      set_mul(1'b1, 32'd100, 32'd200, 1'b0);
      @(negedge clk);
      mif.mul_flush = 1'b1;
      @(negedge clk);
      check("flush_no_done", {63'd0, mif.mul_done}, 64'd0);
      check("flush_state",   64'(mif.mul_state), 64'(MUL_IDLE));
      mif.mul_flush = 1'b0;
      set_mul(1'b1, 32'd6, 32'd7, 1'b0);
      @(negedge clk);
      check("refill_calc", {63'd0, mif.mul_done}, 64'd0);
      @(negedge clk);
      check("refill_done", {63'd0, mif.mul_done}, 64'd1);
      check("refill_out",  mif.mul_out, 64'd42);
      set_mul(1'b0, 32'd0, 32'd0, 1'b0);
      @(negedge clk);

      // Reset during CALC discards the operation and clears the product.
      set_mul(1'b1, 32'd7, 32'd9, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("rst_calc_done",  {63'd0, mif.mul_done}, 64'd0);
      check("rst_calc_out",   mif.mul_out, 64'd0);
      check("rst_calc_state", 64'(mif.mul_state), 64'(MUL_IDLE));
      rst_n = 1'b1;
      set_mul(1'b0, 32'd0, 32'd0, 1'b0);
      @(negedge clk);

      // Back-to-back randomized multiplies, en held across operations.
      ra = $urandom(); rb = $urandom(); rs = 1'($urandom_range(0, 1));
      set_mul(1'b1, ra, rb, rs);
      exp_q.push_back(mul_model(ra, rb, rs));
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("b2b_calc", {63'd0, mif.mul_done}, 64'd0);
         mif.mul_a = $urandom();
         mif.mul_b = $urandom();
         @(negedge clk);
         check("b2b_done", {63'd0, mif.mul_done}, 64'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("b2b_out", mif.mul_out, e);
         end
         if (i < 19) begin
            ra = $urandom(); rb = $urandom(); rs = 1'($urandom_range(0, 1));
            set_mul(1'b1, ra, rb, rs);
            exp_q.push_back(mul_model(ra, rb, rs));
         end else begin
            set_mul(1'b0, 32'd0, 32'd0, 1'b0);
         end
         @(negedge clk);
         check("b2b_idle", {63'd0, mif.mul_done}, 64'd0);
      end
`else
      // Combinational multiplier: result and done in the same cycle.
      set_mul(1'b0, 32'd0, 32'd0, 1'b0);
      #1;
      check("comb_no_en", {63'd0, mif.mul_done}, 64'd0);
      set_mul(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
      #1;
      check("comb_max_done", {63'd0, mif.mul_done}, 64'd1);
      check("comb_max_out",  mif.mul_out, 64'hFFFFFFFE00000001);
      set_mul(1'b1, 32'hFFFFFFFE, 32'd3, 1'b1);
      #1;
      check("comb_signed", mif.mul_out, 64'hFFFFFFFFFFFFFFFA);
      set_mul(1'b1, 32'hFFFFFFFE, 32'd3, 1'b0);
      #1;
      check("comb_unsigned", mif.mul_out, 64'h00000002FFFFFFFA);
      mif.mul_flush = 1'b1;
      #1;
      check("comb_flush", {63'd0, mif.mul_done}, 64'd0);
      mif.mul_flush = 1'b0;
      rst_n = 1'b0;
      #1;
      check("comb_rst_done", {63'd0, mif.mul_done}, 64'd1);
      check("comb_rst_out",  mif.mul_out, 64'h00000002FFFFFFFA);
      rst_n = 1'b1;
      for (int i = 0; i < 40; i++) begin
         ra = $urandom(); rb = $urandom(); rs = 1'($urandom_range(0, 1));
         set_mul(1'b1, ra, rb, rs);
         exp_q.push_back(mul_model(ra, rb, rs));
         #1;
         check("comb_rand_done", {63'd0, mif.mul_done}, 64'd1);
         e = exp_q.pop_front();
         check("comb_rand_out", mif.mul_out, e);
      end
      set_mul(1'b0, 32'd0, 32'd0, 1'b0);
`endif

      @(negedge clk);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/alu_bru_mul.md
# alu_bru_mul

Execute-stage arithmetic core of the CPU pipeline. It bundles three units. A combinational 32-bit ALU computes results and branch/jump targets. A combinational branch-resolution comparator (BRU) decides taken/not-taken. A multi-cycle 32×32→64 multiplier uses an en/done handshake, and the execute stage stalls until it completes. Operands arrive already forwarded from the execute stage.

## Interface
Parameters:
- none; datapath fixed at 32 bits.

Ports (clock and reset: `clk`, `rst_n` — reset is synchronous, active-low):
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- alu_op  in  4  ALU operation (alu_op_t)
- alu_a, alu_b  in  32  ALU operands
- alu_out  out  32  ALU result
- bru_op  in  3  branch condition (bru_op_t)
- bru_a, bru_b  in  32  compare operands (rj, rd/rk)
- br_taken  out  1  branch taken
- mul_en  in  1  multiply request; held high until mul_done
- mul_signed  in  1  1 = both operands two's complement, 0 = unsigned
- mul_flush  in  1  abort in-flight multiply
- mul_a, mul_b  in  32  multiplicands
- mul_out  out  64  product
- mul_done  out  1  product valid, one-cycle pulse

## Operation
- ALU operations (alu_op_t):
  - ADD=0, SUB=1: a+b and a−b, modulo 2^32.
  - SLT=2: signed a<b, result 1 or 0. SLTU=3: unsigned a<b, result 1 or 0.
  - AND=4, OR=5, XOR=6, NOR=7: bitwise.
  - SLL=8, SRL=9, SRA=10: shift a by b[4:0].
  - PASSB=11: out=b (LU12I).
  - Codes 12–15: out=0.
- BRU operations (bru_op_t):
  - NONE=0 gives 0; ALWAYS=7 gives 1.
  - EQ=1, NE=2: equality tests.
  - LT=3, GE=4: signed compares.
  - LTU=5, GEU=6: unsigned compares.
- Multiplier states: IDLE → CALC → DONE → IDLE.
  - IDLE: on mul_en=1, capture mul_a, mul_b and mul_signed, then go to CALC.
  - CALC: compute the 64-bit product into an output register, then go to DONE.
  - DONE: mul_done=1 for that single cycle, mul_out valid. Unconditionally return to IDLE next cycle.
  - mul_out holds its value until the next DONE.
  - mul_en=1 in the cycle after DONE starts a new operation.
- Signed mode: sign-extend both operands to 64 bits. Unsigned mode: zero-extend. mul_out is the full 64-bit product; the caller selects [31:0] or [63:32].
- mul_flush=1 in any state forces IDLE next cycle and suppresses mul_done. Flush has priority over mul_en in the same cycle.
- Operand changes on mul_a/mul_b after capture have no effect on the product.

## Timing
- ALU and BRU: zero latency, purely combinational.
- Multiplier latency: mul_en first high at cycle N gives mul_done=1 at N+2.
- Reset: state IDLE, mul_done=0, mul_out=0. Reset mid-operation discards the operation.

## Configuration
- `EXU_MUL_PIPE_EN` defined: 3-state multi-cycle multiplier as described above.
- `EXU_MUL_PIPE_EN` undefined: single-cycle combinational multiplier.
  - mul_done = mul_en & ~mul_flush.
  - mul_out = product of the current inputs.
  - No state registers; reset has no effect on this path.

## Structure
- Shared package `exu_pkg` holds alu_op_t, bru_op_t and the u32_t/u64_t typedefs.
- ALU and BRU are inline always_comb blocks.
- Sub-module `mul_unit` holds the multiplier FSM and product register.

## Test plan
- ALU: SUB 5−7 → 0xFFFFFFFE. SLT 0xFFFFFFFF vs 1 → 1. SLTU same → 0. SRA 0x80000000 by 4 → 0xF8000000. SLL by b=0x21 → shift by 1.
- BRU: LT −1 vs 0 → 1. LTU 0xFFFFFFFF vs 0 → 0. GEU equal operands → 1. NONE → 0. ALWAYS → 1.
- Multiplier timing: unsigned 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE00000001, done exactly 2 cycles after en, for one cycle only.
- Signed multiply: −2×3 → 0xFFFFFFFFFFFFFFFA. Unsigned with the same operands → 0x00000002FFFFFFFA.
- Flush: mul_flush in CALC → no done. A new en afterwards completes normally 2 cycles later.
- Reset: reset asserted during CALC → done=0 and out=0 next cycle; back-to-back multiplies give correct results each time.
